// File: rtl/regfile_operand_arbiter.sv
// Round-robin arbiter that shares a single-port 16x32 operand register file between requesters.
// Issues one registered access per cycle, tags read returns, and sequences whole-file clears.
module regfile_operand_arbiter #(
  parameter int unsigned ID_WIDTH = 2,
  parameter int unsigned A_WIDTH  = 4,
  parameter int unsigned D_WIDTH  = 32,
  localparam int unsigned NUM_REQ = 2 ** ID_WIDTH
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [NUM_REQ-1:0]           Req,
  input  logic [NUM_REQ-1:0]           Req_RW,
  input  logic [NUM_REQ*A_WIDTH-1:0]   Req_Addr,
  input  logic [NUM_REQ*D_WIDTH-1:0]   Req_Data,
  output logic [NUM_REQ-1:0]           Gnt,
  output logic                         Rd_Valid,
  output logic [ID_WIDTH-1:0]          Rd_Id,
  output logic [D_WIDTH-1:0]           Rd_Data,
  input  logic                         Clr_Req,
  output logic                         Clr_Done,
  output logic                         Rf_En,
  output logic                         Rf_RW,
  output logic [A_WIDTH-1:0]           Rf_Addr,
  output logic [D_WIDTH-1:0]           Rf_Data_In,
  output logic                         Rf_Rst,
  input  logic [D_WIDTH-1:0]           Rf_Data_Out
);

  typedef enum logic [1:0] {StArb, StClear, StDone} state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [ID_WIDTH-1:0] gnt_id, idx;
  logic                gnt_any, gnt_fire;

  logic                rf_en_q, rf_rw_q, rf_rst_q, clr_done_q;
  logic [A_WIDTH-1:0]  rf_addr_q;
  logic [D_WIDTH-1:0]  rf_data_q;
  logic                s1_valid_q, s2_valid_q;
  logic [ID_WIDTH-1:0] s1_id_q, s2_id_q;

  // First set request at or after the pointer, wrapping; looks only at Req.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ptr_q + ID_WIDTH'(i);
      if (!gnt_any && Req[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  assign gnt_fire = Rst && (state_q == StArb) && !Clr_Req && gnt_any;
  assign Gnt      = gnt_fire ? (NUM_REQ'(1) << gnt_id) : '0;
  assign ptr_d    = gnt_fire ? (gnt_id + ID_WIDTH'(1)) : ptr_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StArb:   if (Clr_Req) state_d = StClear;
      StClear: state_d = StDone;
      StDone:  state_d = StArb;
      default: state_d = StArb;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= StArb;
      ptr_q      <= '0;
      rf_en_q    <= 1'b0;
      rf_rw_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
      rf_rst_q   <= 1'b1;
      clr_done_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rf_en_q    <= gnt_fire;
      if (gnt_fire) begin
        rf_rw_q   <= Req_RW[gnt_id];
        rf_addr_q <= Req_Addr[gnt_id*A_WIDTH +: A_WIDTH];
        rf_data_q <= Req_Data[gnt_id*D_WIDTH +: D_WIDTH];
        s1_id_q   <= gnt_id;
      end
      s1_valid_q <= gnt_fire && !Req_RW[gnt_id];
      s2_valid_q <= s1_valid_q;
      s2_id_q    <= s1_id_q;
      // Clear strobe spans the CLEAR cycle so the file zeroes at the edge ending it.
      rf_rst_q   <= (state_d == StClear);
      clr_done_q <= (state_d == StDone);
    end
  end

  assign Rf_En      = rf_en_q;
  assign Rf_RW      = rf_rw_q;
  assign Rf_Addr    = rf_addr_q;
  assign Rf_Data_In = rf_data_q;
  assign Rf_Rst     = rf_rst_q;
  assign Clr_Done   = clr_done_q;
  assign Rd_Valid   = s2_valid_q;
  assign Rd_Id      = s2_id_q;
  assign Rd_Data    = Rf_Data_Out;

endmodule

// File: tb/tb_regfile_operand_arbiter.sv
// Directed bench for regfile_operand_arbiter with a behavioural 16x32 register file attached.
module tb_regfile_operand_arbiter;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [3:0]   Req, Req_RW, Gnt;
  logic [15:0]  Req_Addr;
  logic [127:0] Req_Data;
  logic         Rd_Valid, Clr_Req, Clr_Done;
  logic [1:0]   Rd_Id;
  logic [31:0]  Rd_Data, Rf_Data_In, Rf_Data_Out;
  logic         Rf_En, Rf_RW, Rf_Rst;
  logic [3:0]   Rf_Addr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  regfile_operand_arbiter dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Req_RW(Req_RW), .Req_Addr(Req_Addr),
    .Req_Data(Req_Data), .Gnt(Gnt), .Rd_Valid(Rd_Valid), .Rd_Id(Rd_Id), .Rd_Data(Rd_Data),
    .Clr_Req(Clr_Req), .Clr_Done(Clr_Done), .Rf_En(Rf_En), .Rf_RW(Rf_RW), .Rf_Addr(Rf_Addr),
    .Rf_Data_In(Rf_Data_In), .Rf_Rst(Rf_Rst), .Rf_Data_Out(Rf_Data_Out)
  );

  // Register file: synchronous clear, 1-cycle registered read, zero output when not reading.
  logic [31:0] mem [16];
  always @(posedge Clk) begin
    if (Rf_Rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      Rf_Data_Out <= '0;
    end else if (Rf_En && Rf_RW) begin
      mem[Rf_Addr] <= Rf_Data_In;
      Rf_Data_Out  <= '0;
    end else if (Rf_En) begin
      Rf_Data_Out <= mem[Rf_Addr];
    end else begin
      Rf_Data_Out <= '0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic mid();
    @(negedge Clk);
  endtask

  task automatic set_req(input int id, input logic rw, input logic [3:0] addr,
                         input logic [31:0] data);
    Req[id]              = 1'b1;
    Req_RW[id]           = rw;
    Req_Addr[id*4 +: 4]  = addr;
    Req_Data[id*32 +: 32] = data;
  endtask

  task automatic apply_reset();
    Rst = 1'b0;
    Req = '0;
    cyc();
    cyc();
    Rst = 1'b1;
    cyc();
  endtask

  logic [3:0] rb_addr [3];

  initial begin
    Rst = 1'b0; Req = '0; Req_RW = '0; Req_Addr = '0; Req_Data = '0; Clr_Req = 1'b0;
    rb_addr[0] = 4'd3; rb_addr[1] = 4'd5; rb_addr[2] = 4'd7;

    // Reset release
    for (int c = 0; c < 3; c++) begin
      mid();
      check("rst_rf_rst", Rf_Rst, 1);
      check("rst_rf_en", Rf_En, 0);
      check("rst_gnt", Gnt, 0);
      check("rst_rd_valid", Rd_Valid, 0);
      cyc();
    end
    Rst = 1'b1;
    cyc();
    mid();
    check("rel_rf_rst", Rf_Rst, 0);
    check("rel_rf_en", Rf_En, 0);
    check("rel_gnt", Gnt, 0);
    check("rel_rd_valid", Rd_Valid, 0);
    cyc();

    // Single write then read by requester 2
    set_req(2, 1'b1, 4'd5, 32'hDEADBEEF);
    mid(); check("wr_gnt", Gnt, 4'b0100); cyc();
    set_req(2, 1'b0, 4'd5, 32'h0);
    mid();
    check("rd_gnt", Gnt, 4'b0100);
    check("wr_cmd_en", Rf_En, 1);
    check("wr_cmd_rw", Rf_RW, 1);
    check("wr_cmd_addr", Rf_Addr, 5);
    check("wr_cmd_data", Rf_Data_In, 32'hDEADBEEF);
    cyc();
    Req = '0;
    mid(); check("rd_t1_valid", Rd_Valid, 0); check("rd_t1_rw", Rf_RW, 0); cyc();
    mid();
    check("rd_valid", Rd_Valid, 1);
    check("rd_id", Rd_Id, 2);
    check("rd_data", Rd_Data, 32'hDEADBEEF);
    cyc();
    mid(); check("rd_valid_drop", Rd_Valid, 0); cyc();

    // Round-robin fairness, all reads
    apply_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 4'(i), 32'h0);
    for (int c = 0; c < 10; c++) begin
      if (c == 8) Req = '0;
      mid();
      if (c < 8) check("rr_gnt", Gnt, 32'(4'b0001 << (c % 4)));
      else check("rr_gnt_idle", Gnt, 0);
      if (c >= 2) begin
        check("rr_valid", Rd_Valid, 1);
        check("rr_id", Rd_Id, 32'((c - 2) % 4));
      end
      cyc();
    end
    mid(); check("rr_drain", Rd_Valid, 0); cyc();

    // Sparse wrap: Req=1001 from Ptr=0
    Req = 4'b1001;
    for (int c = 0; c < 4; c++) begin
      mid();
      check("wrap_gnt", Gnt, (c % 2 == 0) ? 32'h1 : 32'h8);
      cyc();
    end
    Req = '0;
    cyc();
    cyc();

    // Clear sequencing
    set_req(1, 1'b1, 4'd7, 32'h1234);
    mid(); check("clr_wr_gnt", Gnt, 4'b0010); cyc();
    set_req(1, 1'b0, 4'd7, 32'h0);
    mid(); check("clr_pre_rd_gnt", Gnt, 4'b0010); cyc();
    Clr_Req = 1'b1;
    mid(); check("clr_req_gnt", Gnt, 0); check("clr_req_done", Clr_Done, 0); cyc();
    Clr_Req = 1'b0;
    mid();
    check("clear_gnt", Gnt, 0);
    check("clear_rf_rst", Rf_Rst, 1);
    check("clear_rf_en", Rf_En, 0);
    check("clear_done", Clr_Done, 0);
    check("pre_clr_valid", Rd_Valid, 1);
    check("pre_clr_data", Rd_Data, 32'h1234);
    cyc();
    mid();
    check("done_gnt", Gnt, 0);
    check("done_pulse", Clr_Done, 1);
    check("done_rf_rst", Rf_Rst, 0);
    cyc();
    mid(); check("post_clr_gnt", Gnt, 4'b0010); check("done_once", Clr_Done, 0); cyc();
    Req = '0;
    mid(); check("post_clr_t1", Rd_Valid, 0); cyc();
    mid();
    check("post_clr_valid", Rd_Valid, 1);
    check("post_clr_id", Rd_Id, 1);
    check("post_clr_data", Rd_Data, 32'h0);
    cyc();

    // Reset in the cycle after a read grant
    set_req(0, 1'b1, 4'd3, 32'hA5A5A5A5);
    mid(); check("mr_wr_gnt", Gnt, 4'b0001); cyc();
    set_req(0, 1'b0, 4'd3, 32'h0);
    mid(); check("mr_rd_gnt", Gnt, 4'b0001); cyc();
    Rst = 1'b0;
    Req = '0;
    #1;
    check("mr_async_rf_rst", Rf_Rst, 1);
    check("mr_async_rf_en", Rf_En, 0);
    for (int c = 0; c < 2; c++) begin
      mid(); check("mr_rst_valid", Rd_Valid, 0); cyc();
    end
    Rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      mid(); check("mr_rel_valid", Rd_Valid, 0); cyc();
    end
    for (int c = 0; c < 5; c++) begin
      if (c < 3) set_req(2, 1'b0, rb_addr[c], 32'h0);
      else Req = '0;
      mid();
      if (c < 3) check("mr_rb_gnt", Gnt, 4'b0100);
      if (c >= 2) begin
        check("mr_rb_valid", Rd_Valid, 1);
        check("mr_rb_id", Rd_Id, 2);
        check("mr_rb_data", Rd_Data, 32'h0);
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_operand_arbiter.md
Name: regfile_operand_arbiter

Overview:
- Shares the single-port operand register file (16 x 32, synchronous, 1-cycle registered read, active-high synchronous clear) between NUM_REQ requesters.
- Uses round-robin arbitration and issues at most one registered access per cycle.
- Returns read data tagged with the requester ID.
- Sequences a whole-file clear on request, and holds the register file in clear while the arbiter is in reset.

Parameters:
- ID_WIDTH, 2, requester index width; NUM_REQ = 2**ID_WIDTH (4).
- A_WIDTH, 4, register file address width.
- D_WIDTH, 32, data width.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous reset, active-low.
- Req  in  NUM_REQ  per-requester access request (level).
- Req_RW  in  NUM_REQ  per-requester 1=write, 0=read.
- Req_Addr  in  NUM_REQ*A_WIDTH  packed addresses; requester i at [i*A_WIDTH +: A_WIDTH].
- Req_Data  in  NUM_REQ*D_WIDTH  packed write data, same packing.
- Gnt  out  NUM_REQ  one-hot combinational grant; request is consumed at the edge closing the Gnt cycle.
- Rd_Valid  out  1  read data for a granted read present this cycle.
- Rd_Id  out  ID_WIDTH  requester owning Rd_Data.
- Rd_Data  out  D_WIDTH  read data, direct from Rf_Data_Out.
- Clr_Req  in  1  request full register-file clear.
- Clr_Done  out  1  one-cycle pulse when the clear is complete.
- Rf_En  out  1  register file enable (registered).
- Rf_RW  out  1  register file RW (registered).
- Rf_Addr  out  A_WIDTH  register file address (registered).
- Rf_Data_In  out  D_WIDTH  register file write data (registered).
- Rf_Rst  out  1  register file synchronous clear, active-high (registered).
- Rf_Data_Out  in  D_WIDTH  register file read data.

Behaviour:
- Reset values while Rst=0:
  - Gnt=0, Rf_En=0, Rf_RW=0, Rf_Addr=0, Rf_Data_In=0.
  - Rf_Rst=1 (register file cleared during reset).
  - Rd_Valid=0, Rd_Id=0, Clr_Done=0, Ptr=0, state=ARB, pipeline valid bits=0.
- First edge after Rst rises: Rf_Rst loads 0.
- FSM ARB:
  - If Clr_Req=1: Gnt=0, next state CLEAR.
  - Otherwise Gnt = first set Req bit searching Ptr, Ptr+1, ... wrapping modulo NUM_REQ.
  - At the edge with a grant to k:
    - Rf_En<=1, Rf_RW<=Req_RW[k], Rf_Addr<=Req_Addr[k], Rf_Data_In<=Req_Data[k].
    - Ptr<=k+1 mod NUM_REQ.
    - Stage-1 tag <= {read=~Req_RW[k], id=k}.
  - At an edge with no grant: Rf_En<=0; Rf_RW, Rf_Addr and Rf_Data_In hold.
- FSM CLEAR (1 cycle):
  - Rf_Rst=1, Rf_En=0, Gnt=0.
  - Next state DONE.
- FSM DONE (1 cycle):
  - Clr_Done=1, Rf_Rst=0, Gnt=0.
  - Next state ARB.
  - Clr_Req is ignored outside ARB; if it is still high on return to ARB, another clear starts.
- Clear/read ordering: a read issued at the edge that sampled Clr_Req still returns its pre-clear data. Clear takes effect at the edge ending CLEAR, after that data has been presented.
- Throughput: one access per cycle, back-to-back; the same requester may be granted consecutively only if no other Req bit is set.
- Read latency (grant in cycle T):
  - Command on Rf_* in T+1.
  - Rf_Data_Out valid in T+2.
  - Rd_Valid=1, Rd_Id=k in T+2, driven from a two-stage tag pipeline.
- Writes: no Rd_Valid pulse; the write lands at the edge ending T+1.
- Outside Rd_Valid, Rd_Data carries the register file's zeroed output and is don't-care.
- Requesters hold Req/operands until they see Gnt, then deassert or present the next request.
- Gnt must not depend on Req_RW, Req_Addr or Req_Data.
- Reset mid-operation: all pipeline tags drop, no Rd_Valid is produced for in-flight reads, Rf_Rst asserts immediately (async).
- Reads following writes to the same address in back-to-back grants return the new data; the register file is serial, so no bypass logic is needed.

Test Plan:
- Reset release:
  - Stimulus: Rst low 3 cycles, then high, no Req.
  - Required: Rf_Rst=1 during reset, 0 from the first edge after release; Rf_En=0, Gnt=0, Rd_Valid=0.
- Single write then read:
  - Stimulus: requester 2 writes 0xDEADBEEF to addr 5, then reads addr 5.
  - Required: Gnt=4'b0100 both cycles; Rd_Valid=1, Rd_Id=2, Rd_Data=0xDEADBEEF exactly 2 cycles after the read grant.
- Round-robin fairness:
  - Stimulus: all four Req held high 8 cycles, all reads, after reset.
  - Required: grant order 0,1,2,3,0,1,2,3; Rd_Id follows the same order at +2 cycles.
- Sparse wrap:
  - Stimulus: Req=4'b1001 held, starting from Ptr=0.
  - Required: grants alternate 0,3,0,3.
- Clear sequencing:
  - Stimulus: write 0x1234 to addr 7; read addr 7 while asserting Clr_Req in the same cycle; then read addr 7 again after Clr_Done.
  - Required: the first read is not granted in the Clr_Req cycle.
  - Required: Gnt=0 for the CLEAR and DONE cycles, with Clr_Done pulsing once 2 cycles after Clr_Req was sampled.
  - Required: the post-clear read returns 0x00000000.
- Reset mid-read:
  - Stimulus: grant a read, pull Rst low in the next cycle.
  - Required: no Rd_Valid pulse; after release, the register file reads 0 at all addresses.
